move_unpacker: RTL and testbench

MOVE_UNPACKER -- requirements
Module: move_unpacker

---
 rtl/chess_pkg.sv | 45 ++++
 rtl/move_unpacker_if.sv | 25 ++
 rtl/mvu_slot_pick.sv | 22 ++
 rtl/move_unpacker.sv | 126 ++++++++++++
 tb/tb_move_unpacker.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared chess constants: piece/colour codes, move field layout and FIFO word geometry.
package chess_pkg;

    localparam int MOVE_W     = 19;
    localparam int SLOT_N     = 8;
    localparam int SLOT_IDX_W = 3;
    localparam int FIFO_W     = 160;
    localparam int WORD_W     = MOVE_W * SLOT_N;
    localparam int SQ_W       = 6;
    localparam int FLAG_W     = 7;

    // Flag bits inside the 7-bit flag field, and their absolute position in a move.
    localparam int FLAG_CAPTURE     = 0;
    localparam int FLAG_PROMOTE     = 1;
    localparam int FLAG_CASTLE      = 2;
    localparam int FLAG_EN_PASSANT  = 3;
    localparam int FLAG_INVALID     = 6;
    localparam int MOVE_CAPTURE_BIT = 2 * SQ_W + FLAG_CAPTURE;
    localparam int MOVE_INVALID_BIT = 2 * SQ_W + FLAG_INVALID;

    localparam logic [MOVE_W-1:0] INVALID_MOVE = 19'h40000;

    typedef enum logic [2:0] {
        PIECE_NONE   = 3'd0,
        PIECE_PAWN   = 3'd1,
        PIECE_KNIGHT = 3'd2,
        PIECE_BISHOP = 3'd3,
        PIECE_ROOK   = 3'd4,
        PIECE_QUEEN  = 3'd5,
        PIECE_KING   = 3'd6
    } piece_e;

    typedef enum logic {
        COLOUR_WHITE = 1'b0,
        COLOUR_BLACK = 1'b1
    } colour_e;

    typedef logic [MOVE_W-1:0] move_t;

    function automatic move_t slot_of(input logic [WORD_W-1:0] word,
                                      input logic [SLOT_IDX_W-1:0] k);
        return word[int'(k) * MOVE_W +: MOVE_W];
    endfunction

endpackage

// File: rtl/move_unpacker_if.sv
// FIFO-read and move-stream signals of the move unpacker; master is the unpacker side.
interface move_unpacker_if;
    import chess_pkg::*;

    logic [FIFO_W-1:0] fifoOut;
    logic              fifoEmpty;
    logic              sqDone;
    logic              rden;
    logic              mvValid;
    logic              mvReady;
    logic [MOVE_W-1:0] mvData;
    logic [7:0]        mvCount;
    logic              allDone;

    modport master (
        input  fifoOut, fifoEmpty, sqDone, mvReady,
        output rden, mvValid, mvData, mvCount, allDone
    );

    modport slave (
        output fifoOut, fifoEmpty, sqDone, mvReady,
        input  rden, mvValid, mvData, mvCount, allDone
    );

endinterface

// File: rtl/mvu_slot_pick.sv
// Combinational priority encoder: index of the highest set bit of an 8-bit slot mask.
module mvu_slot_pick
    import chess_pkg::*;
(
    input  logic [SLOT_N-1:0]     i_mask,
    output logic [SLOT_IDX_W-1:0] o_idx,
    output logic                  o_any
);

    always_comb begin
        // NOTE: both outputs get a default before the loop so no path leaves them unassigned (no latch).
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < SLOT_N; k++) begin
            if (i_mask[k]) begin
                o_idx = SLOT_IDX_W'(k);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_unpacker.sv
// Reads square-unit FIFO words and streams their valid moves, highest slot first.
// Build option MVU_CAPTURE_FIRST_EN: emit a word's capture moves before its quiet moves.
module move_unpacker
    import chess_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    move_unpacker_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_SCAN = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]            r_state;
    logic [WORD_W-1:0]     r_word;
    logic [SLOT_N-1:0]     r_pending;
    logic [7:0]            r_count;

    logic [SLOT_N-1:0]     w_load_mask;
    logic [SLOT_N-1:0]     w_pending_next;
    logic [SLOT_IDX_W-1:0] w_all_idx;
    logic [SLOT_IDX_W-1:0] w_sel_idx;
    logic                  w_all_any;
    logic                  w_accept;
    move_t                 w_move;
    logic                  w_unused_hi;

    assign w_unused_hi = ^bus.fifoOut[FIFO_W-1:WORD_W];

    // A slot is pending only if its invalid flag is clear, so invalid moves never reach mvData.
    always_comb begin
        w_load_mask = '0;
        for (int k = 0; k < SLOT_N; k++) begin
            w_load_mask[k] = ~bus.fifoOut[k * MOVE_W + MOVE_INVALID_BIT];
        end
    end

    mvu_slot_pick u_pick_all (
        .i_mask (r_pending),
        .o_idx  (w_all_idx),
        .o_any  (w_all_any)
    );

`ifdef MVU_CAPTURE_FIRST_EN
    logic [SLOT_N-1:0]     w_cap_mask;
    logic [SLOT_IDX_W-1:0] w_cap_idx;
    logic                  w_cap_any;

    always_comb begin
        w_cap_mask = '0;
        for (int k = 0; k < SLOT_N; k++) begin
            w_cap_mask[k] = r_pending[k] & r_word[k * MOVE_W + MOVE_CAPTURE_BIT];
        end
    end

    mvu_slot_pick u_pick_cap (
        .i_mask (w_cap_mask),
        .o_idx  (w_cap_idx),
        .o_any  (w_cap_any)
    );

    assign w_sel_idx = w_cap_any ? w_cap_idx : w_all_idx;
`else
    assign w_sel_idx = w_all_idx;
`endif

    assign w_move   = slot_of(r_word, w_sel_idx);
    assign w_accept = bus.mvValid & bus.mvReady;

    always_comb begin
        w_pending_next = r_pending;
        if (w_accept) begin
            w_pending_next[w_sel_idx] = 1'b0;
        end
    end

    // Outputs derive from registered state; a stalled move stays put because nothing changes.
    assign bus.mvValid = (r_state == S_SCAN) && w_all_any;
    assign bus.mvData  = bus.mvValid ? w_move : '0;
    assign bus.rden    = reset && (r_state == S_IDLE) && !bus.fifoEmpty;
    assign bus.allDone = (r_state == S_FIN);
    assign bus.mvCount = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the word buffer is a plain register and is cleared so a reset drops any held word.
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (!bus.fifoEmpty) begin
                        r_state <= S_READ;
                    end else if (bus.sqDone) begin
                        r_state <= S_FIN;
                    end
                end
                S_READ: r_state <= S_LOAD;
                S_LOAD: begin
                    r_word    <= bus.fifoOut[WORD_W-1:0];
                    r_pending <= w_load_mask;
                    r_state   <= S_SCAN;
                end
                S_SCAN: begin
                    r_pending <= w_pending_next;
                    if (w_pending_next == '0) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FIN:   r_state <= S_FIN;
                default: r_state <= S_IDLE;
            endcase

            if (w_accept && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_move_unpacker.sv
// Scoreboard bench for move_unpacker: FIFO model, reference emission order, random and directed words.
module tb_move_unpacker;
    import chess_pkg::*;

    logic clk = 1'b0;
    logic reset;

    move_unpacker_if bus ();

    move_unpacker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;

    logic [FIFO_W-1:0] push_q[$];
    logic [FIFO_W-1:0] fifo_q[$];
    logic [MOVE_W-1:0] exp_q[$];

    logic [FIFO_W-1:0] fifo_out_r   = '0;
    logic              fifo_empty_r = 1'b1;
    logic              hold_active  = 1'b0;
    logic [MOVE_W-1:0] held_data    = '0;

    assign bus.fifoOut   = fifo_out_r;
    assign bus.fifoEmpty = fifo_empty_r;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Word with random squares/flags; valid[k]=0 marks slot k invalid, cap[k] sets its capture flag.
    function automatic logic [FIFO_W-1:0] make_word(input logic [7:0] valid, input logic [7:0] cap);
        logic [FIFO_W-1:0] w;
        logic [MOVE_W-1:0] m;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < SLOT_N; k++) begin
            m = w[k*MOVE_W +: MOVE_W];
            m[18] = ~valid[k];
            m[12] = cap[k];
            w[k*MOVE_W +: MOVE_W] = m;
        end
        return w;
    endfunction

    // Reference order: descending slot index, captures first when that build option is on.
    task automatic expect_word(input logic [FIFO_W-1:0] w);
        logic [MOVE_W-1:0] m;
`ifdef MVU_CAPTURE_FIRST_EN
        for (int k = SLOT_N - 1; k >= 0; k--) begin
            m = w[k*MOVE_W +: MOVE_W];
            if (!m[18] && m[12]) exp_q.push_back(m);
        end
        for (int k = SLOT_N - 1; k >= 0; k--) begin
            m = w[k*MOVE_W +: MOVE_W];
            if (!m[18] && !m[12]) exp_q.push_back(m);
        end
`else
        for (int k = SLOT_N - 1; k >= 0; k--) begin
            m = w[k*MOVE_W +: MOVE_W];
            if (!m[18]) exp_q.push_back(m);
        end
`endif
    endtask

    task automatic push_word(input logic [FIFO_W-1:0] w);
        push_q.push_back(w);
        expect_word(w);
    endtask

    // FIFO model without show-ahead: data appears the cycle after rden; pushes land on the next edge.
    always @(posedge clk) begin
        if (bus.rden) begin
            n_checks++;
            if (bus.fifoEmpty || fifo_q.size() == 0) begin
                $display("FAIL rden_when_empty: rden=1 fifoEmpty=%0b level=%0d", bus.fifoEmpty, fifo_q.size());
            end else begin
                n_pass++;
                fifo_out_r <= fifo_q.pop_front();
            end
        end
        while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
        fifo_empty_r <= (fifo_q.size() == 0);
    end

    // Monitor: pops the scoreboard on every accepted move and checks stall stability.
    always @(negedge clk) begin
        if (hold_active) begin
            check("stall_valid", bus.mvValid, 1);
            check("stall_data", bus.mvData, held_data);
        end
        if (bus.mvValid && bus.mvReady) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_move: got 0x%0h expected no move", bus.mvData);
            end else begin
                check("move_order", bus.mvData, exp_q.pop_front());
            end
            check("move_count", bus.mvCount, (n_acc > 255) ? 255 : n_acc);
            n_acc++;
            hold_active = 1'b0;
        end else if (bus.mvValid) begin
            hold_active = 1'b1;
            held_data   = bus.mvData;
        end else begin
            hold_active = 1'b0;
        end
    end

    task automatic wait_valid(input string name, input int bound);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!bus.mvValid && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check(name, bus.mvValid, 1);
    endtask

    task automatic drain(input string name, input int bound);
        int cyc;
        bus.mvReady = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || push_q.size() != 0) && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check(name, exp_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FIFO_W-1:0] w;
        logic [MOVE_W-1:0] s7, first;
        int lat, run, held, gap, vcnt;
        logic rd2;

        reset       = 1'b0;
        bus.sqDone  = 1'b0;
        bus.mvReady = 1'b0;

        // Single valid move in slot 7, queued while reset holds: rden must stay low.
        w = '0;
        for (int k = 0; k < 7; k++) w[k*MOVE_W +: MOVE_W] = INVALID_MOVE;
        w[7*MOVE_W +: MOVE_W] = {7'b0000000, 6'o12, 6'o13};
        push_word(w);
        repeat (3) @(negedge clk);
        check("rst_fifo_has_data", bus.fifoEmpty, 0);
        check("rst_rden", bus.rden, 0);
        check("rst_mvValid", bus.mvValid, 0);
        check("rst_mvData", bus.mvData, 0);
        check("rst_mvCount", bus.mvCount, 0);
        check("rst_allDone", bus.allDone, 0);

        bus.mvReady = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;

        lat = 0;
        @(negedge clk);
        while (!bus.rden && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("one_rden", bus.rden, 1);
        lat = 0;
        rd2 = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) rd2 = bus.rden;
        end while (!bus.mvValid && lat < 10);
        check("one_rden_single_cycle", rd2, 0);
        check("one_latency", lat, 3);
        check("one_mvData", bus.mvData, 19'h0028B);
        @(negedge clk);
        check("one_valid_one_cycle", bus.mvValid, 0);
        check("one_count", bus.mvCount, 1);
        drain("one_drain", 50);

        // Slots 7,4,0 back-to-back, then the next word's rden right after.
        @(posedge clk); #1;
        push_word(make_word(8'b1001_0001, 8'h00));
        push_word(make_word(8'b0000_1000, 8'h00));
        wait_valid("three_wait", 20);
        run = 0;
        while (bus.mvValid && run < 10) begin
            run++;
            @(negedge clk);
        end
        check("three_run", run, 3);
        check("three_next_rden", bus.rden, 1);
        drain("three_drain", 100);

        // Same pattern with a 5-cycle stall on the first move.
        @(posedge clk); #1;
        bus.mvReady = 1'b0;
        w = make_word(8'b1001_0001, 8'h00);
        s7 = w[7*MOVE_W +: MOVE_W];
        push_word(w);
        wait_valid("stall_wait", 20);
        held = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.mvValid && bus.mvData == s7) held++;
            @(posedge clk); #1;
            if (c == 4) bus.mvReady = 1'b1;
            @(negedge clk);
        end
        if (bus.mvValid && bus.mvData == s7) held++;
        check("stall_held_cycles", held, 6);
        drain("stall_drain", 100);

        // Slot 6 quiet, slot 2 capture.
        @(posedge clk); #1;
        w = make_word(8'b0100_0100, 8'b0000_0100);
        push_word(w);
        wait_valid("cap_wait", 20);
        first = bus.mvData;
`ifdef MVU_CAPTURE_FIRST_EN
        check("cap_first", first, w[2*MOVE_W +: MOVE_W]);
`else
        check("cap_first", first, w[6*MOVE_W +: MOVE_W]);
`endif
        drain("cap_drain", 100);

        // All-invalid word costs one SCAN cycle: rden-to-rden spacing of 4.
        @(posedge clk); #1;
        push_word(make_word(8'h00, $urandom));
        push_word(make_word(8'h01, $urandom));
        gap = 0;
        @(negedge clk);
        while (!bus.rden && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("empty_first_rden", bus.rden, 1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.rden && gap < 20);
        check("empty_word_spacing", gap, 4);
        drain("empty_drain", 100);

        // Random words under random backpressure.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] vm;
            vm = '0;
            for (int k = 0; k < SLOT_N; k++) vm[k] = ($urandom_range(0, 2) != 0);
            if (i % 13 == 5) vm = '0;
            push_word(make_word(vm, $urandom));
        end
        run = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || push_q.size() != 0) && run < 6000) begin
            @(posedge clk); #1;
            bus.mvReady = ($urandom_range(0, 3) != 0);
            run++;
        end
        check("rand_drain", exp_q.size(), 0);
        drain("rand_tail", 50);

        // Reset in the middle of a stalled word drops it.
        @(posedge clk); #1;
        bus.mvReady = 1'b0;
        push_word(make_word(8'b1010_1000, 8'h00));
        wait_valid("rstmid_wait", 20);
        @(posedge clk); #2;
        hold_active = 1'b0;
        reset = 1'b0;
        #1;
        check("rstmid_mvValid", bus.mvValid, 0);
        check("rstmid_mvCount", bus.mvCount, 0);
        check("rstmid_mvData", bus.mvData, 0);
        check("rstmid_rden", bus.rden, 0);
        exp_q.delete();
        n_acc = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.mvReady = 1'b1;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mvValid) vcnt++;
        end
        check("rstmid_no_resume", vcnt, 0);

        // 300 single-move words: count saturates.
        for (int i = 0; i < 300; i++) push_word(make_word(8'h01 << $urandom_range(0, 7), $urandom));
        drain("sat_drain", 3000);
        check("sat_count", bus.mvCount, 255);

        // Square unit done with an empty FIFO: FIN next cycle, sticky.
        @(posedge clk); #1;
        bus.sqDone = 1'b1;
        @(negedge clk);
        check("fin_not_yet", bus.allDone, 0);
        @(negedge clk);
        check("fin_allDone", bus.allDone, 1);
        check("fin_rden", bus.rden, 0);
        check("fin_mvValid", bus.mvValid, 0);
        push_q.push_back(make_word(8'hFF, 8'h00));
        repeat (5) @(negedge clk);
        check("fin_sticky_fifo", bus.fifoEmpty, 0);
        check("fin_sticky_rden", bus.rden, 0);
        check("fin_sticky_allDone", bus.allDone, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
